// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared constants and helpers for the pipelined adder.
// Stage-count derivation, geometry check and CPU status flag layout.
package pipe_adder_pkg;

  // Bit positions of the adder flags in the CPU status register.
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_W = 3;

  // Packed so that co lands on FLAG_C, ovf on FLAG_V, zero on FLAG_Z.
  typedef struct packed {
    logic zero;
    logic ovf;
    logic co;
  } flags_t;

  function automatic int calc_stages(
    input int width,
    input int chunk
  );
    return width / chunk;
  endfunction

  function automatic bit chunk_ok(
    input int width,
    input int chunk
  );
    return (chunk > 0) && (width >= chunk)
        && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: N-bit generate/propagate ripple slice.
// Ports: a, b, ci in; s sum, co carry out, c_msb_in carry into bit N-1.
module adder_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a | b;

  // Ripple kept in one block so the chain is a single evaluation.
  always_comb begin
    c = '0;
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s        = a ^ b ^ c[N-1:0];
  assign co       = c[N];
  assign c_msb_in = c[N-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit add/sub, one CHUNK-bit slice per stage.
// Ports: clk, rst, in_valid/in_ready, a, b, sub, ci in; out_valid/out_ready, s, co, ovf, zero out.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);
  localparam int LAST   = STAGES - 1;

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad
    $error("pipe_adder: WIDTH must be a multiple of CHUNK");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // The whole pipe freezes while the consumer refuses a result.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign b_eff = sub ? ~b : b;
  assign c0    = ci ^ sub;

  // Stage k sees slices k..STAGES-1 of the operands at bit 0 upward,
  // and the finished sum slices 0..k-1 from the previous stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RW = (STAGES - k) * CHUNK;
    localparam int SW = (k + 1) * CHUNK;

    logic [RW-1:0]    src_a;
    logic [RW-1:0]    src_b;
    logic             src_c;
    logic             src_v;
    logic [CHUNK-1:0] xs;
    logic             xco;
    logic [SW-1:0]    sum_d;
    logic [SW-1:0]    sum_q;
    logic             vld_q;

    if (k == 0) begin : g_head
      assign src_a = a;
      assign src_b = b_eff;
      assign src_c = c0;
      assign src_v = in_valid;
      assign sum_d = xs;
    end else begin : g_body
      assign src_a = g_stg[k-1].g_mid.ra_q;
      assign src_b = g_stg[k-1].g_mid.rb_q;
      assign src_c = g_stg[k-1].g_mid.cry_q;
      assign src_v = g_stg[k-1].vld_q;
      assign sum_d = {xs, g_stg[k-1].sum_q};
    end

    if (k == LAST) begin : g_tail
      logic xcm;

      adder_chunk #(
        .N(CHUNK)
      ) u_chunk (
        .a       (src_a[CHUNK-1:0]),
        .b       (src_b[CHUNK-1:0]),
        .ci      (src_c),
        .s       (xs),
        .co      (xco),
        .c_msb_in(xcm)
      );
    end else begin : g_mid
      logic [RW-CHUNK-1:0] ra_q;
      logic [RW-CHUNK-1:0] rb_q;
      logic                cry_q;

      adder_chunk #(
        .N(CHUNK)
      ) u_chunk (
        .a       (src_a[CHUNK-1:0]),
        .b       (src_b[CHUNK-1:0]),
        .ci      (src_c),
        .s       (xs),
        .co      (xco),
        .c_msb_in()
      );

      // Unconsumed operand slices ride along with the beat.
      always_ff @(posedge clk) begin
        if (rst) begin
          ra_q  <= '0;
          rb_q  <= '0;
          cry_q <= 1'b0;
        end else if (!stall) begin
          ra_q  <= src_a[RW-1:CHUNK];
          rb_q  <= src_b[RW-1:CHUNK];
          cry_q <= xco;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        sum_q <= '0;
      end else if (!stall) begin
        vld_q <= src_v;
        sum_q <= sum_d;
      end
    end
  end

  flags_t fl_d;
  flags_t fl_q;

  assign fl_d.co   = g_stg[LAST].xco;
  assign fl_d.ovf  = g_stg[LAST].g_tail.xcm ^ g_stg[LAST].xco;
  assign fl_d.zero = ~|g_stg[LAST].sum_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      fl_q <= '0;
    end else if (!stall) begin
      fl_q <= fl_d;
    end
  end

  assign out_valid = g_stg[LAST].vld_q;
  assign s         = g_stg[LAST].sum_q;
  assign co        = fl_q.co;
  assign ovf       = fl_q.ovf;
  assign zero      = fl_q.zero;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (32/8).
// Directed vectors, streaming, backpressure and reset scenarios.
module tb_pipe_adder;

  localparam int W  = 32;
  localparam int C  = 8;
  localparam int ST = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    logic         zero;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;
  logic         zero;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_adder #(
    .WIDTH(W),
    .CHUNK(C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .ci       (ci),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .co       (co),
    .ovf      (ovf),
    .zero     (zero)
  );

  function automatic res_t model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         m,
    input logic         c
  );
    logic [W-1:0] ye;
    logic [W:0]   f;
    res_t         r;
    ye     = m ? ~y : y;
    f      = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, c ^ m};
    r.s    = f[W-1:0];
    r.co   = f[W];
    r.ovf  = (x[W-1] == ye[W-1]) && (r.s[W-1] != x[W-1]);
    r.zero = (r.s == '0);
    return r;
  endfunction

  task automatic send_one(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         m,
    input logic         c
  );
    @(negedge clk);
    a = x;
    b = y;
    sub = m;
    ci = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 32) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int bad_v;
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 32'h1234_5678;
    b = 32'h1;
    sub = 1'b0;
    ci = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, s, co, ovf, zero, in_ready} !==
        {1'b0, 32'h0, 3'b000, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state got v=%b s=%h c=%b o=%b z=%b r=%b need 0/0/0/0/0/1",
               out_valid, s, co, ovf, zero, in_ready);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    bad_v = 0;
    for (int t = 0; t < ST + 3; t++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad_v++;
    end
    n_cmp++;
    if (bad_v != 0) begin
      n_bad++;
      $display("FAIL reset_drop got %0d valid cycles need 0", bad_v);
    end
  endtask

  task automatic test_add_wrap();
    int   lat;
    res_t e;
    res_t g;
    sb.push_back(res_t'({32'h0000_0000, 1'b1, 1'b0, 1'b1}));
    send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_out(lat);
    n_cmp++;
    if (lat != ST || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL add_wrap_lat got %0d need %0d", lat, ST);
    end
    e = sb.pop_front();
    g = {s, co, ovf, zero};
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL add_wrap got %h need %h", g, e);
    end
  endtask

  task automatic test_ovf();
    int   lat;
    res_t e;
    res_t g;
    sb.push_back(res_t'({32'h8000_0000, 1'b0, 1'b1, 1'b0}));
    send_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_out(lat);
    n_cmp++;
    if (lat != ST || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_add_lat got %0d need %0d", lat, ST);
    end
    e = sb.pop_front();
    g = {s, co, ovf, zero};
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL ovf_add got %h need %h", g, e);
    end
    sb.push_back(res_t'({32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}));
    send_one(32'h8000_0000, 32'h1, 1'b1, 1'b0);
    wait_out(lat);
    n_cmp++;
    if (lat != ST || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sub_lat got %0d need %0d", lat, ST);
    end
    e = sb.pop_front();
    g = {s, co, ovf, zero};
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL ovf_sub got %h need %h", g, e);
    end
  endtask

  task automatic test_sub_borrow();
    int   lat;
    res_t e;
    res_t g;
    sb.push_back(res_t'({32'h0000_0001, 1'b1, 1'b0, 1'b0}));
    send_one(32'd5, 32'd3, 1'b1, 1'b1);
    wait_out(lat);
    n_cmp++;
    if (lat != ST || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL sub_bin_lat got %0d need %0d", lat, ST);
    end
    e = sb.pop_front();
    g = {s, co, ovf, zero};
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL sub_bin got %h need %h", g, e);
    end
    sb.push_back(res_t'({32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}));
    send_one(32'd3, 32'd5, 1'b1, 1'b0);
    wait_out(lat);
    n_cmp++;
    if (lat != ST || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL sub_neg_lat got %0d need %0d", lat, ST);
    end
    e = sb.pop_front();
    g = {s, co, ovf, zero};
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL sub_neg got %h need %h", g, e);
    end
  endtask

  task automatic test_back_to_back();
    int   got = 0;
    int   bad_rdy = 0;
    int   bad_tim = 0;
    res_t e;
    res_t g;
    out_ready = 1'b1;
    for (int t = 0; t < 16 + ST + 8; t++) begin
      @(negedge clk);
      if (out_valid) begin
        if (t != got + ST) bad_tim++;
        g = {s, co, ovf, zero};
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_extra got beat %h need none", g);
        end else begin
          e = sb.pop_front();
          if (g !== e) begin
            n_bad++;
            $display("FAIL b2b[%0d] got %h need %h", got, g, e);
          end
        end
        got++;
      end
      if (t < 16) begin
        a = $urandom;
        b = $urandom;
        sub = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        if (in_ready !== 1'b1) bad_rdy++;
        sb.push_back(model(a, b, sub, ci));
      end else begin
        in_valid = 1'b0;
      end
    end
    n_cmp++;
    if (bad_rdy != 0) begin
      n_bad++;
      $display("FAIL b2b_ready got %0d low cycles need 0", bad_rdy);
    end
    n_cmp++;
    if (bad_tim != 0) begin
      n_bad++;
      $display("FAIL b2b_timing got %0d late beats need 0", bad_tim);
    end
    n_cmp++;
    if (got != 16 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_count got %0d left %0d need 16/0", got, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_backpressure();
    int   sent = 0;
    int   got = 0;
    int   stalls = 0;
    int   bad_rdy = 0;
    int   bad_frz = 0;
    logic acc = 1'b0;
    res_t snap = '0;
    res_t e;
    res_t g;
    for (int t = 0; t < 80 && (sent < 12 || got < 12); t++) begin
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      out_ready = !(t >= 8 && t <= 10);
      #1;
      g = {s, co, ovf, zero};
      if (out_valid && !out_ready) begin
        stalls++;
        if (in_ready !== 1'b0) bad_rdy++;
        if (stalls == 1) snap = g;
        else if (g !== snap) bad_frz++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL bp_extra got beat %h need none", g);
        end else begin
          e = sb.pop_front();
          if (g !== e) begin
            n_bad++;
            $display("FAIL bp[%0d] got %h need %h", got, g, e);
          end
        end
        got++;
      end
      if (!in_valid && sent < 12) begin
        a = $urandom;
        b = $urandom;
        sub = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        sb.push_back(model(a, b, sub, ci));
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (stalls != 3) begin
      n_bad++;
      $display("FAIL bp_stalls got %0d need 3", stalls);
    end
    n_cmp++;
    if (bad_rdy != 0) begin
      n_bad++;
      $display("FAIL bp_ready got %0d high cycles need 0", bad_rdy);
    end
    n_cmp++;
    if (bad_frz != 0) begin
      n_bad++;
      $display("FAIL bp_frozen got %0d changes need 0", bad_frz);
    end
    n_cmp++;
    if (got != 12 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL bp_count got %0d left %0d need 12/0", got, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_midflight();
    int   lat;
    int   bad_v = 0;
    res_t e;
    res_t g;
    out_ready = 1'b1;
    @(negedge clk);
    a = 32'h1111_1111;
    b = 32'h2222_2222;
    sub = 1'b0;
    ci = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    a = 32'h3333_3333;
    @(negedge clk);
    a = 32'h4444_4444;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int t = 0; t < ST + 4; t++) begin
      if (out_valid !== 1'b0) bad_v++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad_v != 0) begin
      n_bad++;
      $display("FAIL rst_flush got %0d valid cycles need 0", bad_v);
    end
    sb.push_back(model(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0));
    send_one(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);
    wait_out(lat);
    n_cmp++;
    if (lat != ST || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_relat got %0d need %0d", lat, ST);
    end
    e = sb.pop_front();
    g = {s, co, ovf, zero};
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL rst_data got %h need %h", g, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    ci = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_add_wrap();
    test_ovf();
    test_sub_borrow();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
